motor_cmd_sequencer: RTL and testbench
======================================

MOTOR_CMD_SEQUENCER -- requirements
Module: motor_cmd_sequencer

Interface
REQ-001 Parameter DEAD_CYCLES, default 1250000, number of cycles the speed field is held at stop during a direction reversal (10 ms at 125 MHz).
REQ-002 Parameter RAMP_CYCLES, default 12500000, number of cycles speed 01 is held when starting from stop toward speed 10.
REQ-003 Parameter TIMEOUT_CYCLES, default 62500000, number of cycles without a new command before the watchdog forces stop.
REQ-004 clk  input  1  system clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 cmd_valid  input  1  single-cycle strobe indicating that cmd_in is a new gesture command.
REQ-007 cmd_in  input  4  requested command: [3:2] speed code, [1:0] steer code.
REQ-008 cmd_nibble  output  4  sequenced command driven to the motor controller, registered.
REQ-009 seq_state  output  2  current state encoding: STOP=00, RUN=01, RAMP=10, DEAD=11.
REQ-010 timeout  output  1  sticky watchdog-expired flag.

Function
REQ-011 Speed codes SHALL be: 00 stop, 01 normal forward, 10 fast forward, 11 reverse. Steer codes SHALL be: 00 straight, 10 left, 01 right. Steer 11 SHALL be replaced with 00 when latched.
REQ-012 The effective target SHALL be cmd_in (sanitised) when cmd_valid=1, and the stored target register otherwise. The target register SHALL load the sanitised cmd_in on every cmd_valid.
REQ-013 Every cmd_valid SHALL clear timeout, clear the watchdog counter, and be accepted in any state; there is no back-pressure.
REQ-014 The watchdog counter SHALL increment while cmd_valid=0 and saturate at TIMEOUT_CYCLES. On the cycle it reaches TIMEOUT_CYCLES, the target SHALL be forced to 0000 and timeout SHALL be set. If cmd_valid is asserted in that same cycle, the command SHALL win.
REQ-015 Direction SHALL be reverse when speed is 11 and forward when speed is 01 or 10. A reversal SHALL mean that the current output speed and the effective target speed are both nonzero and differ in direction.
REQ-016 STOP: cmd_nibble speed=00, steer=00.
  - Target speed 00: stay in STOP.
  - Target speed 01 or 11: go to RUN, with cmd_nibble=target on the same edge.
  - Target speed 10: go to RAMP, with cmd_nibble={01, target steer} and the timer loaded with RAMP_CYCLES-1.
REQ-017 RUN:
  - Target speed 00: go to STOP.
  - Reversal: go to DEAD, with cmd_nibble=0000 and the timer loaded with DEAD_CYCLES-1.
  - Otherwise: cmd_nibble SHALL take the target on each edge; a change between 01 and 10 is applied directly.
REQ-018 RAMP: speed SHALL be held at 01 and steer SHALL track the target.
  - Target speed 00: go to STOP.
  - Target speed 11: go to DEAD.
  - Target speed 01: go to RUN.
  - Timer reaches 0 with target 10: go to RUN, with cmd_nibble=target.
REQ-019 DEAD: cmd_nibble SHALL be 0000 for exactly DEAD_CYCLES cycles, then the block SHALL go to STOP. A target of 00 SHALL go to STOP immediately.
REQ-020 Latency from cmd_valid to a cmd_nibble change SHALL be 1 clock edge, in states where the command is applied directly.
REQ-021 cmd_nibble SHALL never transition directly between a forward speed and 11. Every reversal SHALL pass through at least DEAD_CYCLES cycles of speed 00.
REQ-022 Timer and watchdog counters SHALL be 32-bit unsigned. Parameters equal to 0 or 1 SHALL behave as a 1-cycle hold.

Reset
REQ-023 When reset is asserted, the block SHALL asynchronously set: cmd_nibble=0000, seq_state=STOP, timeout=0, target=0000, timer=0, watchdog counter=0.
REQ-024 Reset asserted mid-RAMP or mid-DEAD SHALL abandon the sequence. After release, the block SHALL be in STOP and act on the next cmd_valid.

Structure
REQ-025 The state encoding and the speed/steer code constants SHALL reside in the shared package motor_pkg.
REQ-026 A single sub-module, seq_timer (loadable 32-bit down-counter with a zero flag), SHALL be used for the RAMP and DEAD holds.

Verification
REQ-027 The bench SHALL use DEAD_CYCLES=4, RAMP_CYCLES=8, TIMEOUT_CYCLES=20 and cover the following scenarios.
REQ-028 From STOP, cmd 1000 -> cmd_nibble=0100 for 8 cycles, then 1000; seq_state goes RAMP then RUN.
REQ-029 In RUN at 0100, cmd 1100 -> cmd_nibble=0000 for exactly 4 cycles in DEAD, then STOP, then 1100 on the next edge.
REQ-030 In RUN at 0110, no cmd_valid for 20 cycles -> cmd_nibble=0000 and timeout=1. A subsequent cmd 0100 -> timeout=0 and cmd_nibble=0100 after 1 edge.
REQ-031 cmd 0111 from STOP -> cmd_nibble=0100 (steer sanitised). Also: cmd_valid coincident with the watchdog expiry cycle -> the command applied and timeout stays 0.
REQ-032 Reset asserted 3 cycles into RAMP -> cmd_nibble=0000 and seq_state=00 immediately. After release, cmd 0100 -> RUN 0100 after 1 edge.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared encodings for the motor command sequencer: state codes, speed/steer
// codes and small helpers used by the top and the bench.
package motor_pkg;

  typedef enum logic [1:0] {
    ST_STOP = 2'b00,
    ST_RUN  = 2'b01,
    ST_RAMP = 2'b10,
    ST_DEAD = 2'b11
  } seq_state_e;

  localparam logic [1:0] SPD_STOP = 2'b00;
  localparam logic [1:0] SPD_NORM = 2'b01;
  localparam logic [1:0] SPD_FAST = 2'b10;
  localparam logic [1:0] SPD_REV  = 2'b11;

  localparam logic [1:0] STR_STRAIGHT = 2'b00;
  localparam logic [1:0] STR_RIGHT    = 2'b01;
  localparam logic [1:0] STR_LEFT     = 2'b10;

  // Steer 11 is not a legal motor code; it collapses to straight.
  function automatic logic [3:0] sanitise(input logic [3:0] c);
    return {c[3:2], (c[1:0] == 2'b11) ? STR_STRAIGHT : c[1:0]};
  endfunction

  function automatic logic is_rev(input logic [1:0] spd);
    return spd == SPD_REV;
  endfunction

  // Down-counter preload for an N-cycle hold; 0 and 1 both mean one cycle.
  function automatic logic [31:0] hold_load(input logic [31:0] n);
    return (n > 32'd1) ? n - 32'd1 : 32'd0;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable 32-bit down-counter with zero flag, used for the RAMP and DEAD holds.
module seq_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic        zero
);

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)               cnt_d = load_val;
    else if (cnt_q != '0)   cnt_d = cnt_q - 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/motor_cmd_sequencer.sv
// Turns gesture commands into a safe motor command stream: ramps up to fast,
// inserts a dead time on direction reversals and stops on watchdog expiry.
module motor_cmd_sequencer
  import motor_pkg::*;
#(
  parameter int unsigned DEAD_CYCLES    = 1250000,
  parameter int unsigned RAMP_CYCLES    = 12500000,
  parameter int unsigned TIMEOUT_CYCLES = 62500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [3:0] cmd_in,
  output logic [3:0] cmd_nibble,
  output logic [1:0] seq_state,
  output logic       timeout
);

  localparam logic [31:0] WD_MAX = (TIMEOUT_CYCLES > 32'd1) ? TIMEOUT_CYCLES : 32'd1;

  seq_state_e  state_q, state_d;
  logic [3:0]  nib_q, nib_d;
  logic [3:0]  tgt_q, tgt_d;
  logic [31:0] wd_q, wd_d;
  logic        timeout_q, timeout_d;
  logic        wd_expire;
  logic [3:0]  tgt_eff;
  logic [1:0]  tspd;
  logic        reversal;
  logic        tmr_load, tmr_zero;
  logic [31:0] tmr_val;

  // A command arriving on the expiry cycle wins over the forced stop.
  always_comb begin
    wd_expire = !cmd_valid && (wd_q == WD_MAX - 32'd1);
    tgt_eff   = cmd_valid ? sanitise(cmd_in) : (wd_expire ? 4'b0000 : tgt_q);
    tgt_d     = tgt_eff;
    wd_d      = cmd_valid ? 32'd0 : ((wd_q == WD_MAX) ? wd_q : wd_q + 32'd1);
    timeout_d = cmd_valid ? 1'b0 : (wd_expire ? 1'b1 : timeout_q);
    tspd      = tgt_eff[3:2];
    reversal  = (nib_q[3:2] != SPD_STOP) && (tspd != SPD_STOP) &&
                (is_rev(nib_q[3:2]) != is_rev(tspd));
  end

  always_comb begin
    state_d  = state_q;
    nib_d    = nib_q;
    tmr_load = 1'b0;
    tmr_val  = 32'd0;
    case (state_q)
      ST_STOP: begin
        nib_d = 4'b0000;
        if (tspd == SPD_FAST) begin
          state_d  = ST_RAMP;
          nib_d    = {SPD_NORM, tgt_eff[1:0]};
          tmr_load = 1'b1;
          tmr_val  = hold_load(RAMP_CYCLES);
        end else if (tspd != SPD_STOP) begin
          state_d = ST_RUN;
          nib_d   = tgt_eff;
        end
      end
      ST_RUN: begin
        if (tspd == SPD_STOP) begin
          state_d = ST_STOP;
          nib_d   = 4'b0000;
        end else if (reversal) begin
          state_d  = ST_DEAD;
          nib_d    = 4'b0000;
          tmr_load = 1'b1;
          tmr_val  = hold_load(DEAD_CYCLES);
        end else begin
          nib_d = tgt_eff;
        end
      end
      ST_RAMP: begin
        case (tspd)
          SPD_STOP: begin
            state_d = ST_STOP;
            nib_d   = 4'b0000;
          end
          SPD_REV: begin
            state_d  = ST_DEAD;
            nib_d    = 4'b0000;
            tmr_load = 1'b1;
            tmr_val  = hold_load(DEAD_CYCLES);
          end
          SPD_NORM: begin
            state_d = ST_RUN;
            nib_d   = tgt_eff;
          end
          default: begin
            if (tmr_zero) begin
              state_d = ST_RUN;
              nib_d   = tgt_eff;
            end else begin
              nib_d = {SPD_NORM, tgt_eff[1:0]};
            end
          end
        endcase
      end
      default: begin
        nib_d = 4'b0000;
        if (tspd == SPD_STOP || tmr_zero) state_d = ST_STOP;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_STOP;
      nib_q     <= 4'b0000;
      tgt_q     <= 4'b0000;
      wd_q      <= 32'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      nib_q     <= nib_d;
      tgt_q     <= tgt_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  seq_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  assign cmd_nibble = nib_q;
  assign seq_state  = state_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Directed scenarios plus a randomized run against a rule-level reference model.
module tb_motor_cmd_sequencer;

  localparam int DEAD = 4;
  localparam int RAMP = 8;
  localparam int TO   = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [3:0] cmd_in = 4'b0000;
  logic [3:0] cmd_nibble;
  logic [1:0] seq_state;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  motor_cmd_sequencer #(
    .DEAD_CYCLES   (DEAD),
    .RAMP_CYCLES   (RAMP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_in     (cmd_in),
    .cmd_nibble (cmd_nibble),
    .seq_state  (seq_state),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  // Reference model: phase name, output, and how many hold cycles remain.
  logic [3:0] m_out;
  logic [1:0] m_st;
  bit         m_to;
  logic [3:0] m_tgt;
  int         m_idle;
  int         m_left;

  task automatic model_reset();
    m_out = 4'b0000; m_st = 2'b00; m_to = 0; m_tgt = 4'b0000; m_idle = 0; m_left = 0;
  endtask

  task automatic model_step(input bit v, input logic [3:0] c);
    logic [3:0] t;
    int sp, ost, steer;
    bit fire;
    fire = !v && (m_idle + 1 == TO);
    if (v) t = (c[1:0] == 2'b11) ? {c[3:2], 2'b00} : c;
    else   t = fire ? 4'b0000 : m_tgt;
    m_tgt  = t;
    m_idle = v ? 0 : ((m_idle >= TO) ? TO : m_idle + 1);
    if (v) m_to = 0; else if (fire) m_to = 1;
    sp = int'(t[3:2]); steer = int'(t[1:0]); ost = int'(m_out[3:2]);
    case (m_st)
      2'b00: begin
        if (sp == 2) begin m_st = 2'b10; m_out = 4'(4 + steer); m_left = RAMP; end
        else if (sp != 0) begin m_st = 2'b01; m_out = t; end
      end
      2'b01: begin
        if (sp == 0) begin m_st = 2'b00; m_out = 0; end
        else if ((ost == 3) != (sp == 3)) begin m_st = 2'b11; m_out = 0; m_left = DEAD; end
        else m_out = t;
      end
      2'b10: begin
        if (sp == 0) begin m_st = 2'b00; m_out = 0; end
        else if (sp == 3) begin m_st = 2'b11; m_out = 0; m_left = DEAD; end
        else if (sp == 1 || m_left <= 1) begin m_st = 2'b01; m_out = t; end
        else begin m_left--; m_out = 4'(4 + steer); end
      end
      default: begin
        m_out = 0;
        if (sp == 0 || m_left <= 1) m_st = 2'b00;
        else m_left--;
      end
    endcase
  endtask

  // Inputs are set on the falling edge; outputs are read on the next falling edge.
  task automatic tick();
    if (reset) model_reset();
    else model_step(cmd_valid, cmd_in);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [3:0] c);
    cmd_valid = 1'b1; cmd_in = c;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1; cmd_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (cmd_nibble !== 4'b0000 || seq_state !== 2'b00 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got nib=%b st=%b to=%b, want 0000 00 0", cmd_nibble, seq_state, timeout);
    end
    tick(); tick();
    checks++;
    if (cmd_nibble !== 4'b0000 || seq_state !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle: got nib=%b st=%b, want 0000 00", cmd_nibble, seq_state);
    end
  endtask

  task automatic test_ramp();
    apply_reset();
    send(4'b1000);
    for (int i = 0; i < RAMP; i++) begin
      checks++;
      if (cmd_nibble !== 4'b0100 || seq_state !== 2'b10) begin
        errors++;
        $display("FAIL ramp_hold[%0d]: got nib=%b st=%b, want 0100 10", i, cmd_nibble, seq_state);
      end
      if (i < RAMP - 1) tick();
    end
    tick();
    checks++;
    if (cmd_nibble !== 4'b1000 || seq_state !== 2'b01) begin
      errors++;
      $display("FAIL ramp_done: got nib=%b st=%b, want 1000 01", cmd_nibble, seq_state);
    end
  endtask

  task automatic test_dead();
    apply_reset();
    send(4'b0100);
    checks++;
    if (cmd_nibble !== 4'b0100 || seq_state !== 2'b01) begin
      errors++;
      $display("FAIL dead_pre_run: got nib=%b st=%b, want 0100 01", cmd_nibble, seq_state);
    end
    send(4'b1100);
    for (int i = 0; i < DEAD; i++) begin
      checks++;
      if (cmd_nibble !== 4'b0000 || seq_state !== 2'b11) begin
        errors++;
        $display("FAIL dead_hold[%0d]: got nib=%b st=%b, want 0000 11", i, cmd_nibble, seq_state);
      end
      if (i < DEAD - 1) tick();
    end
    tick();
    checks++;
    if (cmd_nibble !== 4'b0000 || seq_state !== 2'b00) begin
      errors++;
      $display("FAIL dead_stop: got nib=%b st=%b, want 0000 00", cmd_nibble, seq_state);
    end
    tick();
    checks++;
    if (cmd_nibble !== 4'b1100 || seq_state !== 2'b01) begin
      errors++;
      $display("FAIL dead_reverse: got nib=%b st=%b, want 1100 01", cmd_nibble, seq_state);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    send(4'b0110);
    repeat (TO - 1) tick();
    checks++;
    if (cmd_nibble !== 4'b0110 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL wd_before: got nib=%b to=%b, want 0110 0", cmd_nibble, timeout);
    end
    tick();
    checks++;
    if (cmd_nibble !== 4'b0000 || timeout !== 1'b1 || seq_state !== 2'b00) begin
      errors++;
      $display("FAIL wd_expire: got nib=%b to=%b st=%b, want 0000 1 00", cmd_nibble, timeout, seq_state);
    end
    repeat (3) tick();
    checks++;
    if (timeout !== 1'b1) begin
      errors++;
      $display("FAIL wd_sticky: got to=%b, want 1", timeout);
    end
    send(4'b0100);
    checks++;
    if (cmd_nibble !== 4'b0100 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL wd_recover: got nib=%b to=%b, want 0100 0", cmd_nibble, timeout);
    end
  endtask

  task automatic test_sanitise_and_race();
    apply_reset();
    send(4'b0111);
    checks++;
    if (cmd_nibble !== 4'b0100 || seq_state !== 2'b01) begin
      errors++;
      $display("FAIL steer_sanitise: got nib=%b st=%b, want 0100 01", cmd_nibble, seq_state);
    end
    apply_reset();
    send(4'b0100);
    repeat (TO - 1) tick();
    send(4'b0101);
    checks++;
    if (cmd_nibble !== 4'b0101 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL wd_race: got nib=%b to=%b, want 0101 0", cmd_nibble, timeout);
    end
    tick();
    checks++;
    if (cmd_nibble !== 4'b0101 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL wd_race_after: got nib=%b to=%b, want 0101 0", cmd_nibble, timeout);
    end
  endtask

  task automatic test_reset_mid_ramp();
    apply_reset();
    send(4'b1000);
    tick(); tick();
    reset = 1'b1;
    #1;
    checks++;
    if (cmd_nibble !== 4'b0000 || seq_state !== 2'b00) begin
      errors++;
      $display("FAIL async_reset: got nib=%b st=%b, want 0000 00", cmd_nibble, seq_state);
    end
    @(negedge clk);
    tick();
    reset = 1'b0;
    send(4'b0100);
    checks++;
    if (cmd_nibble !== 4'b0100 || seq_state !== 2'b01) begin
      errors++;
      $display("FAIL post_reset_cmd: got nib=%b st=%b, want 0100 01", cmd_nibble, seq_state);
    end
  endtask

  task automatic test_random();
    logic [3:0] prev;
    int gap;
    apply_reset();
    prev = cmd_nibble;
    for (int n = 0; n < 70; n++) begin
      gap = (n % 7 == 6) ? int'($urandom_range(18, 26)) : int'($urandom_range(0, 12));
      for (int k = 0; k <= gap; k++) begin
        if (k == 0) send(4'($urandom_range(0, 15)));
        else tick();
        checks++;
        if (cmd_nibble !== m_out || seq_state !== m_st || timeout !== m_to) begin
          errors++;
          $display("FAIL rand[%0d.%0d]: got nib=%b st=%b to=%b, want %b %b %b",
                   n, k, cmd_nibble, seq_state, timeout, m_out, m_st, m_to);
        end
        checks++;
        if (((prev[3:2] == 2'b01 || prev[3:2] == 2'b10) && cmd_nibble[3:2] == 2'b11) ||
            (prev[3:2] == 2'b11 && (cmd_nibble[3:2] == 2'b01 || cmd_nibble[3:2] == 2'b10))) begin
          errors++;
          $display("FAIL rand_direct_reverse[%0d.%0d]: got %b -> %b, want a stop between", n, k, prev, cmd_nibble);
        end
        prev = cmd_nibble;
      end
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_ramp();
    test_dead();
    test_timeout();
    test_sanitise_and_race();
    test_reset_mid_ramp();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
